// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types and constants for the I2C transaction arbiter.
package i2c_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ = 1'b1;
  localparam int TIMEOUT_CYC_DEF = 4096;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector; first set req bit searching upward from last+1 with wrap.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  // Scanning from the farthest offset down lets the nearest candidate win last.
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(last) + k) % N);
      if (req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sharing of one byte-level I2C master among NUM_REQ requesters.
// Optional watchdog abort of a stalled master is enabled with `define I2C_WDOG_EN.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ),
  parameter int ADDR_W = 7,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [7:0]               rsp_rdata,
  output logic                     rsp_err,
  output logic                     m_start,
  output logic                     m_rw,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [7:0]               m_wdata,
  output logic                     m_abort,
  input  logic                     m_busy,
  input  logic                     m_done,
  input  logic                     m_ack_err,
  input  logic [7:0]               m_rdata
);
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit the 16-bit watchdog");
  end
  state_t state, state_n;
  logic [ID_W-1:0] grant, grant_n, last_grant, last_grant_n, win, rsp_id_n;
  logic found, timeout, rsp_valid_n, rsp_err_n, m_start_n, m_rw_n, m_abort_n;
  logic [NUM_REQ-1:0] req_ready_n;
  logic [7:0] rsp_rdata_n, m_wdata_n;
  logic [ADDR_W-1:0] m_addr_n;
  rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .req(req_valid),
    .last(last_grant),
    .found(found),
    .idx(win)
  );
`ifdef I2C_WDOG_EN
  logic [15:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || state == ST_ISSUE) ? '0 : (state == ST_WAIT) ? cnt + 16'd1 : cnt;
  // A completion in the timeout cycle takes precedence over the abort.
  assign timeout = state == ST_WAIT && cnt == 16'(TIMEOUT_CYC - 1) && !m_done;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_grant_n = last_grant;
    req_ready_n = '0;
    m_start_n = 1'b0;
    m_abort_n = 1'b0;
    rsp_valid_n = 1'b0;
    rsp_id_n = rsp_id;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n = rsp_err;
    m_rw_n = m_rw;
    m_addr_n = m_addr;
    m_wdata_n = m_wdata;
    case (state)
      ST_IDLE: if (found && !m_busy) begin
        state_n = ST_ISSUE;
        grant_n = win;
        req_ready_n = NUM_REQ'(1) << win;
        m_start_n = 1'b1;
        m_rw_n = req_rw[win];
        m_addr_n = req_addr[win*ADDR_W +: ADDR_W];
        m_wdata_n = req_wdata[win*8 +: 8];
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: if (m_done || timeout) begin
        state_n = ST_RESP;
        rsp_valid_n = 1'b1;
        rsp_id_n = grant;
        rsp_rdata_n = (m_done && m_rw == RW_READ) ? m_rdata : 8'h00;
        rsp_err_n = m_done ? m_ack_err : 1'b1;
        m_abort_n = timeout;
      end
      default: begin
        state_n = ST_IDLE;
        last_grant_n = grant;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      grant <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      req_ready <= '0;
      m_start <= 1'b0;
      m_abort <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      m_rw <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last_grant <= last_grant_n;
      req_ready <= req_ready_n;
      m_start <= m_start_n;
      m_abort <= m_abort_n;
      rsp_valid <= rsp_valid_n;
      rsp_id <= rsp_id_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err <= rsp_err_n;
      m_rw <= m_rw_n;
      m_addr <= m_addr_n;
      m_wdata <= m_wdata_n;
    end
  end
endmodule
